pixel_kernel_seq: RTL

//  Parametrised kernel sequencer for the photodiode gradient array. Steps N_PIX pixels in turn.

---
 rtl/pixel_pkg.sv | 21 ++
 rtl/pixel_phase_timer.sv | 35 +++
 rtl/pixel_kernel_seq.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pixel_pkg.sv
// Shared definitions for the photodiode kernel sequencer: phase encoding,
// idle switch pattern and index-width helper.
package pixel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOC   = 3'd1,
    ST_GAP   = 3'd2,
    ST_ADJ   = 3'd3,
    ST_PDONE = 3'd4
  } state_e;

  // Per-bit idle level: switches and v_b1 open/low, complements and v_b0 high.
  localparam logic IDLE_SW  = 1'b0;
  localparam logic IDLE_INV = 1'b1;

  function automatic int idx_width(input int n_pix);
    return (n_pix <= 2) ? 1 : $clog2(n_pix);
  endfunction

endpackage

// File: rtl/pixel_phase_timer.sv
// Phase timer: counts 0..max_i while enabled, flags the final cycle of a phase.
module pixel_phase_timer #(
  parameter int TW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [TW-1:0] max_i,
  output logic          hit_o
);

  logic [TW-1:0] cnt_q, cnt_d;

  assign hit_o = en_i && (cnt_q == max_i);

  // Holds at the threshold rather than wrapping; clear wins over count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !hit_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pixel_kernel_seq.sv
// Kernel sequencer: walks N_PIX pixels through LOC, GAP, ADJ, PDONE and drives
// per-pixel switch/bias vectors registered from the next state.
module pixel_kernel_seq
  import pixel_pkg::*;
#(
  parameter int N_PIX   = 9,
  parameter int TW      = 10,
  parameter int GAP_CYC = 1,
  parameter int IW      = idx_width(N_PIX)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             cont_i,
  input  logic             abort_i,
  input  logic [TW-1:0]    loc_max_i,
  input  logic [TW-1:0]    adj_max_i,
  output logic             busy_o,
  output logic [IW-1:0]    pxl_idx_o,
  output logic [N_PIX-1:0] s_p1_o,
  output logic [N_PIX-1:0] s_p2_o,
  output logic [N_PIX-1:0] s1_o,
  output logic [N_PIX-1:0] s2_o,
  output logic [N_PIX-1:0] s1_inv_o,
  output logic [N_PIX-1:0] s2_inv_o,
  output logic [N_PIX-1:0] v_b1_o,
  output logic [N_PIX-1:0] v_b0_o,
  output logic             pxl_done_o,
  output logic             kernel_done_o
);

  localparam logic [IW-1:0]    LAST_IDX = IW'(N_PIX - 1);
  localparam logic [TW-1:0]    GAP_MAX  = TW'(GAP_CYC - 1);
  localparam logic [N_PIX-1:0] PIX_ONE  = {{(N_PIX-1){1'b0}}, 1'b1};
  localparam logic [N_PIX-1:0] VEC_SW   = {N_PIX{IDLE_SW}};
  localparam logic [N_PIX-1:0] VEC_INV  = {N_PIX{IDLE_INV}};

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   loc_q, loc_d, adj_q, adj_d;
  logic [TW-1:0]   tmr_max;
  logic            tmr_en, tmr_clr, tmr_hit;

  logic [N_PIX-1:0] s_p1_q, s_p2_q, s1_inv_q, s2_inv_q, v_b1_q, v_b0_q;
  logic [N_PIX-1:0] s_p1_d, s_p2_d, v_b1_d;
  logic             busy_q, pxl_done_q, kernel_done_q;
  logic             busy_d, pxl_done_d, kernel_done_d;
  logic [N_PIX-1:0] onehot;

  pixel_phase_timer #(.TW(TW)) u_timer (
    .clk   (clk),
    .rst_n (reset),
    .clr_i (tmr_clr),
    .en_i  (tmr_en),
    .max_i (tmr_max),
    .hit_o (tmr_hit)
  );

  // Cleared outside timed phases and on the last cycle of each, so every
  // phase starts counting from zero.
  assign tmr_clr = abort_i || tmr_hit || !tmr_en;

  always_comb begin
    tmr_en  = 1'b0;
    tmr_max = '0;
    unique case (state_q)
      ST_LOC:  begin tmr_en = 1'b1; tmr_max = loc_q;   end
      ST_GAP:  begin tmr_en = 1'b1; tmr_max = GAP_MAX; end
      ST_ADJ:  begin tmr_en = 1'b1; tmr_max = adj_q;   end
      default: begin tmr_en = 1'b0; tmr_max = '0;      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    loc_d   = loc_q;
    adj_d   = adj_q;
    if (abort_i) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_d = ST_LOC;
            idx_d   = '0;
            loc_d   = loc_max_i;
            adj_d   = adj_max_i;
          end
        end
        ST_LOC:  if (tmr_hit) state_d = ST_GAP;
        ST_GAP:  if (tmr_hit) state_d = ST_ADJ;
        ST_ADJ:  if (tmr_hit) state_d = ST_PDONE;
        ST_PDONE: begin
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (cont_i) begin
              state_d = ST_LOC;
              loc_d   = loc_max_i;
              adj_d   = adj_max_i;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_LOC;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Decode from next state so registered outputs line up with the state register.
  always_comb begin
    onehot        = PIX_ONE << idx_d;
    s_p1_d        = (state_d == ST_LOC) ? onehot : VEC_SW;
    s_p2_d        = (state_d == ST_ADJ) ? onehot : VEC_SW;
    v_b1_d        = s_p1_d | s_p2_d;
    busy_d        = (state_d != ST_IDLE);
    pxl_done_d    = (state_d == ST_PDONE);
    kernel_done_d = (state_d == ST_PDONE) && (idx_d == LAST_IDX);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      loc_q         <= '0;
      adj_q         <= '0;
      s_p1_q        <= VEC_SW;
      s_p2_q        <= VEC_SW;
      s1_inv_q      <= VEC_INV;
      s2_inv_q      <= VEC_INV;
      v_b1_q        <= VEC_SW;
      v_b0_q        <= VEC_INV;
      busy_q        <= 1'b0;
      pxl_done_q    <= 1'b0;
      kernel_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      loc_q         <= loc_d;
      adj_q         <= adj_d;
      s_p1_q        <= s_p1_d;
      s_p2_q        <= s_p2_d;
      s1_inv_q      <= ~s_p1_d;
      s2_inv_q      <= ~s_p2_d;
      v_b1_q        <= v_b1_d;
      v_b0_q        <= ~v_b1_d;
      busy_q        <= busy_d;
      pxl_done_q    <= pxl_done_d;
      kernel_done_q <= kernel_done_d;
    end
  end

  assign busy_o        = busy_q;
  assign pxl_idx_o     = idx_q;
  assign s_p1_o        = s_p1_q;
  assign s1_o          = s_p1_q;
  assign s_p2_o        = s_p2_q;
  assign s2_o          = s_p2_q;
  assign s1_inv_o      = s1_inv_q;
  assign s2_inv_o      = s2_inv_q;
  assign v_b1_o        = v_b1_q;
  assign v_b0_o        = v_b0_q;
  assign pxl_done_o    = pxl_done_q;
  assign kernel_done_o = kernel_done_q;

endmodule
